// File: rtl/jtkcpu_intarb.sv
// jtkcpu_intarb: KCPU interrupt arbiter, pin sync, NMI edge latch and vector sequencing
module jtkcpu_intarb #(
    parameter int SYNC_STAGES = 2,
    parameter bit NMI_ARM     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        nmi_n,
    input  logic        firq_n,
    input  logic        irq_n,
    input  logic [7:0]  cc,
    input  logic        ni,
    input  logic        wai,
    input  logic        halt,
    input  logic        s_loaded,
    input  logic        ack,
    input  logic        done,
    output logic        rst_req,
    output logic        nmi,
    output logic        firq,
    output logic        irq,
    output logic [15:0] vec,
    output logic        full_stk,
    output logic        set_i,
    output logic        set_f,
    output logic        busy
);
    typedef enum logic [1:0] {RSTV, IDLE, PEND, SRV} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sy_nmi, sy_firq, sy_irq;
    logic s_nmi, s_firq, s_irq, s_nmi_d, nmi_lat, armed;
    logic nmi_edge, nmi_req, firq_req, irq_req, eval, ack_nmi;
    logic unused_cc;
    assign s_nmi     = sy_nmi[SYNC_STAGES-1];
    assign s_firq    = sy_firq[SYNC_STAGES-1];
    assign s_irq     = sy_irq[SYNC_STAGES-1];
    assign nmi_edge  = armed & s_nmi_d & ~s_nmi;
    // a fresh edge may be granted in the very cycle it is detected
    assign nmi_req   = nmi_lat | nmi_edge;
    assign firq_req  = ~s_firq & ~cc[6];
    assign irq_req   = ~s_irq & ~cc[4];
    assign eval      = (ni | wai) & ~halt;
    assign ack_nmi   = (state == PEND) & nmi & ack;
    assign busy      = state != IDLE;
    assign unused_cc = &{1'b0, cc[7], cc[5], cc[3:0]};
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RSTV;
            rst_req  <= 1'b1;
            nmi      <= 1'b0;
            firq     <= 1'b0;
            irq      <= 1'b0;
            vec      <= 16'hFFFE;
            full_stk <= 1'b0;
            set_i    <= 1'b1;
            set_f    <= 1'b1;
            nmi_lat  <= 1'b0;
            armed    <= ~NMI_ARM;
            sy_nmi   <= '1;
            sy_firq  <= '1;
            sy_irq   <= '1;
            s_nmi_d  <= 1'b1;
        end else if (cen) begin
            sy_nmi  <= (sy_nmi << 1) | SYNC_STAGES'(nmi_n);
            sy_firq <= (sy_firq << 1) | SYNC_STAGES'(firq_n);
            sy_irq  <= (sy_irq << 1) | SYNC_STAGES'(irq_n);
            s_nmi_d <= s_nmi;
            armed   <= armed | s_loaded;
            // set wins over the clearing ack
            nmi_lat <= nmi_edge | (nmi_lat & ~ack_nmi);
            case (state)
                RSTV: if (ack) begin
                    state   <= SRV;
                    rst_req <= 1'b0;
                end
                IDLE: if (eval & (nmi_req | firq_req | irq_req)) begin
                    state    <= PEND;
                    nmi      <= nmi_req;
                    firq     <= ~nmi_req & firq_req;
                    irq      <= ~nmi_req & ~firq_req;
                    vec      <= nmi_req ? 16'hFFFC : firq_req ? 16'hFFF6 : 16'hFFF8;
                    full_stk <= nmi_req | ~firq_req;
                    set_i    <= 1'b1;
                    set_f    <= nmi_req | firq_req;
                end
                PEND: if (ack) begin
                    state <= SRV;
                    nmi   <= 1'b0;
                    firq  <= 1'b0;
                    irq   <= 1'b0;
                end
                SRV: if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtkcpu_intarb.sv
// tb_jtkcpu_intarb: directed stimulus checked every cycle against a phase/kind model
module tb_jtkcpu_intarb;
    localparam int SYNC_STAGES = 2;
    localparam bit NMI_ARM = 1;
    logic clk = 0, rst = 0, cen = 1, nmi_n = 1, firq_n = 1, irq_n = 1;
    logic [7:0] cc = 8'h00;
    logic ni = 0, wai = 0, halt = 0, s_loaded = 0, ack = 0, done = 0;
    logic rst_req, nmi, firq, irq, full_stk, set_i, set_f, busy;
    logic [15:0] vec;
    int n_cmp = 0, n_bad = 0;

    jtkcpu_intarb #(.SYNC_STAGES(SYNC_STAGES), .NMI_ARM(NMI_ARM)) dut (
        .clk(clk), .rst(rst), .cen(cen), .nmi_n(nmi_n), .firq_n(firq_n), .irq_n(irq_n),
        .cc(cc), .ni(ni), .wai(wai), .halt(halt), .s_loaded(s_loaded), .ack(ack),
        .done(done), .rst_req(rst_req), .nmi(nmi), .firq(firq), .irq(irq), .vec(vec),
        .full_stk(full_stk), .set_i(set_i), .set_f(set_f), .busy(busy)
    );

    always #5 clk = ~clk;

    // model: phase 0=reset fetch 1=idle 2=pending 3=servicing; kind 0=RST 1=NMI 2=FIRQ 3=IRQ
    logic [15:0] vtab [4] = '{16'hFFFE, 16'hFFFC, 16'hFFF6, 16'hFFF8};
    bit ftab [4] = '{0, 1, 0, 1};
    bit ftab_f [4] = '{1, 1, 1, 0};
    int ph, kind, k;
    bit lat, armed_m, prev, mvalid = 0, sn, sf, si, edge_a, nreq;
    bit qn[$], qf[$], qi[$];

    always @(posedge clk) begin
        if (!rst) begin
            ph = 0; kind = 0; lat = 0; armed_m = !NMI_ARM; prev = 1; mvalid = 1;
            qn = {}; qf = {}; qi = {};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                qn.push_back(1); qf.push_back(1); qi.push_back(1);
            end
        end else if (cen && mvalid) begin
            sn = qn[0]; sf = qf[0]; si = qi[0];
            edge_a = armed_m && prev && !sn;
            nreq = lat || edge_a;
            case (ph)
                0: if (ack) ph = 3;
                1: if ((ni || wai) && !halt) begin
                    k = nreq ? 1 : (!sf && !cc[6]) ? 2 : (!si && !cc[4]) ? 3 : 0;
                    if (k != 0) begin ph = 2; kind = k; end
                end
                2: if (ack) begin if (kind == 1) lat = 0; ph = 3; end
                default: if (done) ph = 1;
            endcase
            if (edge_a) lat = 1;
            armed_m = armed_m || s_loaded;
            prev = sn;
            void'(qn.pop_front()); qn.push_back(nmi_n);
            void'(qf.pop_front()); qf.push_back(firq_n);
            void'(qi.pop_front()); qi.push_back(irq_n);
        end
    end

    logic [23:0] dut_v, exp_v;
    assign dut_v = {rst_req, nmi, firq, irq, vec, full_stk, set_i, set_f, busy};
    always @(negedge clk) begin
        if (mvalid) begin
            exp_v = {ph == 0, ph == 2 && kind == 1, ph == 2 && kind == 2, ph == 2 && kind == 3,
                     vtab[kind], ftab[kind], 1'b1, ftab_f[kind], ph != 1};
            n_cmp++;
            if (dut_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle t=%0t outputs dut=%h exp=%h", $time, dut_v, exp_v);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        tick(3);
        chk("rst_rst_req", 16'(rst_req), 16'd1);
        chk("rst_vec", vec, 16'hFFFE);
        chk("rst_busy", 16'(busy), 16'd1);
        rst = 1; tick(2);
        chk("rstv_hold", 16'(rst_req), 16'd1);
        ack = 1; tick(1); ack = 0;
        chk("rstv_ack", 16'(rst_req), 16'd0);
        chk("rstv_srv_busy", 16'(busy), 16'd1);
        done = 1; tick(1); done = 0;
        chk("rstv_done", 16'(busy), 16'd0);
        // NMI edge before arming is lost
        nmi_n = 0; tick(4);
        ni = 1; tick(1); ni = 0;
        chk("nmi_unarmed", 16'(nmi), 16'd0);
        nmi_n = 1; tick(3);
        s_loaded = 1; tick(1); s_loaded = 0;
        nmi_n = 0; tick(3);
        ni = 1; tick(1); ni = 0;
        chk("nmi_grant", 16'(nmi), 16'd1);
        chk("nmi_vec", vec, 16'hFFFC);
        chk("nmi_full", 16'(full_stk), 16'd1);
        ack = 1; tick(1); ack = 0;
        chk("nmi_ack_drop", 16'(nmi), 16'd0);
        done = 1; tick(1); done = 0;
        nmi_n = 1;
        // FIRQ beats IRQ, then IRQ once F is masked
        irq_n = 0; firq_n = 0; cc = 8'h00; tick(3);
        ni = 1; tick(1); ni = 0;
        chk("firq_grant", 16'(firq), 16'd1);
        chk("firq_vec", vec, 16'hFFF6);
        chk("firq_full", 16'(full_stk), 16'd0);
        ack = 1; tick(1); ack = 0;
        cc = 8'h40;
        done = 1; tick(1); done = 0;
        chk("b2b_not_in_done", 16'(irq), 16'd0);
        ni = 1; tick(1); ni = 0;
        chk("irq_grant", 16'(irq), 16'd1);
        chk("irq_vec", vec, 16'hFFF8);
        chk("irq_set_f", 16'(set_f), 16'd0);
        ack = 1; tick(1); ack = 0;
        done = 1; tick(1); done = 0;
        // both masked: nothing, then wai with masks cleared
        cc = 8'h50;
        repeat (3) begin ni = 1; tick(1); ni = 0; tick(1); end
        chk("masked_none", 16'({irq, firq}), 16'd0);
        wai = 1; cc = 8'h00; tick(1); wai = 0;
        chk("wai_firq", 16'(firq), 16'd1);
        ack = 1; tick(1); ack = 0;
        done = 1; tick(1); done = 0;
        firq_n = 1; cc = 8'h40; tick(3);
        // PEND holds its grant against a new NMI and a released IRQ
        ni = 1; tick(1); ni = 0;
        chk("pend_irq", 16'(irq), 16'd1);
        nmi_n = 0; irq_n = 1; tick(5);
        chk("pend_hold_irq", 16'(irq), 16'd1);
        chk("pend_hold_nmi", 16'(nmi), 16'd0);
        ack = 1; tick(1); ack = 0;
        chk("pend_ack", 16'(irq), 16'd0);
        done = 1; tick(1); done = 0;
        ni = 1; tick(1); ni = 0;
        chk("nmi_after", 16'(nmi), 16'd1);
        ack = 1; tick(1); ack = 0;
        done = 1; tick(1); done = 0;
        nmi_n = 1;
        // halt blocks grants, reset aborts service
        irq_n = 0; tick(3);
        halt = 1;
        repeat (2) begin ni = 1; tick(1); ni = 0; tick(1); end
        chk("halt_none", 16'(irq), 16'd0);
        halt = 0;
        ni = 1; tick(1); ni = 0;
        chk("halt_release", 16'(irq), 16'd1);
        ack = 1; tick(1); ack = 0;
        chk("srv_vec", vec, 16'hFFF8);
        rst = 0; tick(1); rst = 1;
        chk("abort_rst_req", 16'(rst_req), 16'd1);
        chk("abort_vec", vec, 16'hFFFE);
        // cen gates the ack
        cen = 0; ack = 1; tick(2);
        chk("cen_gate", 16'(rst_req), 16'd1);
        cen = 1; tick(1); ack = 0;
        chk("cen_ack", 16'(rst_req), 16'd0);
        done = 1; tick(1); done = 0;
        chk("final_idle", 16'(busy), 16'd0);
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
